// File: rtl/debounce_array.sv
// Debounced button and slide-switch front end: 2-flop synchronisers, per-channel
// stability counters, press/release pulses, button auto-repeat and switch-change pulse.
module debounce_array #(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  input  logic [N_SW-1:0]  SW,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] button_out,
  output logic [N_BTN-1:0] button_pulse,
  output logic [N_BTN-1:0] button_release,
  output logic [N_SW-1:0]  SW_OK,
  output logic             sw_change,
  output logic             rst_req
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0] btn_meta_r;
  logic [N_BTN-1:0] btn_sync_r;
  logic [N_SW-1:0]  sw_meta_r;
  logic [N_SW-1:0]  sw_sync_r;

  logic [DB_W-1:0]  btn_cnt_r [N_BTN];
  logic [DB_W-1:0]  sw_cnt_r  [N_SW];
  logic [RP_W-1:0]  rpt_cnt_r [N_BTN];
  logic [N_BTN-1:0] rpt_phase_r;

  logic [N_BTN-1:0] btn_level_r;
  logic [N_SW-1:0]  sw_level_r;
  logic [N_BTN-1:0] btn_pulse_r;
  logic [N_BTN-1:0] btn_release_r;
  logic             sw_change_r;
  logic             rst_req_r;

  logic [N_BTN-1:0] btn_flip_s;
  logic [N_SW-1:0]  sw_flip_s;
  logic [N_BTN-1:0] rpt_clear_s;
  logic [N_BTN-1:0] rpt_fire_s;

  // Level-flip decisions and repeat-counter fire/clear conditions per channel.
  always_comb begin
    btn_flip_s  = '0;
    sw_flip_s   = '0;
    rpt_clear_s = '0;
    rpt_fire_s  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      btn_flip_s[i]  = (btn_sync_r[i] != btn_level_r[i]) && (btn_cnt_r[i] == DB_LAST);
      // A release edge clears the repeat counter so it never fires alongside the release pulse.
      rpt_clear_s[i] = !btn_level_r[i] || !repeat_en ||
                       ((btn_sync_r[i] != btn_level_r[i]) && (btn_cnt_r[i] == DB_LAST));
      if (rpt_phase_r[i]) begin
        rpt_fire_s[i] = !rpt_clear_s[i] && (rpt_cnt_r[i] == RP_PERIOD_LAST);
      end else begin
        rpt_fire_s[i] = !rpt_clear_s[i] && (rpt_cnt_r[i] == RP_DELAY_LAST);
      end
    end
    for (int j = 0; j < N_SW; j++) begin
      sw_flip_s[j] = (sw_sync_r[j] != sw_level_r[j]) && (sw_cnt_r[j] == DB_LAST);
    end
  end

  // Synchronisers, debounce/repeat counters, debounced levels and registered pulses.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      btn_meta_r    <= '0;
      btn_sync_r    <= '0;
      sw_meta_r     <= '0;
      sw_sync_r     <= '0;
      btn_level_r   <= '0;
      sw_level_r    <= '0;
      rpt_phase_r   <= '0;
      btn_pulse_r   <= '0;
      btn_release_r <= '0;
      sw_change_r   <= 1'b0;
      rst_req_r     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        btn_cnt_r[i] <= '0;
        rpt_cnt_r[i] <= '0;
      end
      for (int j = 0; j < N_SW; j++) begin
        sw_cnt_r[j] <= '0;
      end
    end else begin
      btn_meta_r <= button;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= SW;
      sw_sync_r  <= sw_meta_r;

      for (int i = 0; i < N_BTN; i++) begin
        if (btn_sync_r[i] == btn_level_r[i]) begin
          btn_cnt_r[i] <= '0;
        end else if (btn_flip_s[i]) begin
          btn_cnt_r[i]   <= '0;
          btn_level_r[i] <= ~btn_level_r[i];
        end else begin
          btn_cnt_r[i] <= btn_cnt_r[i] + DB_W'(1);
        end

        if (rpt_clear_s[i]) begin
          rpt_cnt_r[i]   <= '0;
          rpt_phase_r[i] <= 1'b0;
        end else if (rpt_fire_s[i]) begin
          rpt_cnt_r[i]   <= '0;
          rpt_phase_r[i] <= 1'b1;
        end else begin
          rpt_cnt_r[i] <= rpt_cnt_r[i] + RP_W'(1);
        end
      end

      for (int j = 0; j < N_SW; j++) begin
        if (sw_sync_r[j] == sw_level_r[j]) begin
          sw_cnt_r[j] <= '0;
        end else if (sw_flip_s[j]) begin
          sw_cnt_r[j]   <= '0;
          sw_level_r[j] <= ~sw_level_r[j];
        end else begin
          sw_cnt_r[j] <= sw_cnt_r[j] + DB_W'(1);
        end
      end

      btn_pulse_r   <= (btn_flip_s & ~btn_level_r) | rpt_fire_s;
      btn_release_r <= btn_flip_s & btn_level_r;
      sw_change_r   <= |sw_flip_s;
      rst_req_r     <= btn_level_r[0];
    end
  end

  assign button_out     = btn_level_r;
  assign button_pulse   = btn_pulse_r;
  assign button_release = btn_release_r;
  assign SW_OK          = sw_level_r;
  assign sw_change      = sw_change_r;
  assign rst_req        = rst_req_r;

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: expected output events are queued when stimulus
// is driven and checked against every output on every cycle.
module tb_debounce_array;

  localparam int NB = 5;
  localparam int NS = 8;
  localparam int LAT = 6;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;
  localparam int K_SW      = 3;

  logic          clk_100mhz = 1'b0;
  logic          rst;
  logic [NB-1:0] button;
  logic [NS-1:0] SW;
  logic          repeat_en;
  logic [NB-1:0] button_out;
  logic [NB-1:0] button_pulse;
  logic [NB-1:0] button_release;
  logic [NS-1:0] SW_OK;
  logic          sw_change;
  logic          rst_req;

  always #5 clk_100mhz = ~clk_100mhz;

  debounce_array #(
    .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .button(button), .SW(SW), .repeat_en(repeat_en),
    .button_out(button_out), .button_pulse(button_pulse), .button_release(button_release),
    .SW_OK(SW_OK), .sw_change(sw_change), .rst_req(rst_req)
  );

  typedef struct { int cyc; int kind; int ch; } ev_t;
  ev_t sb[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [NB-1:0] exp_out = '0;
  logic [NB-1:0] exp_pulse = '0;
  logic [NB-1:0] exp_rel = '0;
  logic [NS-1:0] exp_sw = '0;
  logic          exp_swchg = 1'b0;
  logic          exp_rst_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, want);
    end
  endtask

  task automatic push(input int at, input int kind, input int ch);
    ev_t e;
    e.cyc = at;
    e.kind = kind;
    e.ch = ch;
    sb.push_back(e);
  endtask

  // One clock: update the expectation from due events, then compare every output.
  task automatic tick();
    logic rst_edge;
    int k;
    rst_edge = rst;
    @(posedge clk_100mhz);
    #1;
    cyc++;
    exp_pulse = '0;
    exp_rel = '0;
    exp_swchg = 1'b0;
    if (rst_edge) begin
      exp_out = '0;
      exp_sw = '0;
      exp_rst_req = 1'b0;
      sb.delete();
    end else begin
      exp_rst_req = exp_out[0];
      k = 0;
      while (k < sb.size()) begin
        if (sb[k].cyc == cyc) begin
          case (sb[k].kind)
            K_PRESS:   begin exp_out[sb[k].ch] = 1'b1; exp_pulse[sb[k].ch] = 1'b1; end
            K_RELEASE: begin exp_out[sb[k].ch] = 1'b0; exp_rel[sb[k].ch] = 1'b1; end
            K_REPEAT:  exp_pulse[sb[k].ch] = 1'b1;
            default:   begin exp_sw[sb[k].ch] = ~exp_sw[sb[k].ch]; exp_swchg = 1'b1; end
          endcase
          sb.delete(k);
        end else begin
          k++;
        end
      end
    end
    chk("button_out", 32'(button_out), 32'(exp_out));
    chk("button_pulse", 32'(button_pulse), 32'(exp_pulse));
    chk("button_release", 32'(button_release), 32'(exp_rel));
    chk("SW_OK", 32'(SW_OK), 32'(exp_sw));
    chk("sw_change", 32'(sw_change), 32'(exp_swchg));
    chk("rst_req", 32'(rst_req), 32'(exp_rst_req));
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int p;
    int e;
    rst = 1'b1;
    button = '0;
    SW = '0;
    repeat_en = 1'b0;
    wait_n(3);
    rst = 1'b0;
    wait_n(4);

    // Single press and release on button 1.
    button[1] = 1'b1;
    push(cyc + LAT, K_PRESS, 1);
    wait_n(10);
    button[1] = 1'b0;
    push(cyc + LAT, K_RELEASE, 1);
    wait_n(10);

    // Short glitch on button 2 must be ignored.
    button[2] = 1'b1;
    wait_n(3);
    button[2] = 1'b0;
    wait_n(10);

    // Two switches toggle together: one sw_change pulse.
    SW[0] = 1'b1;
    SW[7] = 1'b1;
    push(cyc + LAT, K_SW, 0);
    push(cyc + LAT, K_SW, 7);
    wait_n(10);
    SW[0] = 1'b0;
    push(cyc + LAT, K_SW, 0);
    wait_n(10);

    // Auto-repeat on button 3 held 30 cycles.
    repeat_en = 1'b1;
    button[3] = 1'b1;
    p = cyc + LAT;
    push(p, K_PRESS, 3);
    for (int t = p + 10; t < p + 30; t += 3) push(t, K_REPEAT, 3);
    wait_n(30);
    button[3] = 1'b0;
    push(cyc + LAT, K_RELEASE, 3);
    wait_n(12);
    repeat_en = 1'b0;
    wait_n(2);

    // repeat_en rising while button 2 is already held.
    button[2] = 1'b1;
    push(cyc + LAT, K_PRESS, 2);
    wait_n(8);
    repeat_en = 1'b1;
    e = cyc;
    push(e + 10, K_REPEAT, 2);
    push(e + 13, K_REPEAT, 2);
    wait_n(8);
    button[2] = 1'b0;
    push(e + 14, K_RELEASE, 2);
    wait_n(10);
    repeat_en = 1'b0;

    // Simultaneous events on independent channels.
    button[1] = 1'b1;
    button[4] = 1'b1;
    SW[3] = 1'b1;
    push(cyc + LAT, K_PRESS, 1);
    push(cyc + LAT, K_PRESS, 4);
    push(cyc + LAT, K_SW, 3);
    wait_n(10);
    button[1] = 1'b0;
    button[4] = 1'b0;
    SW[3] = 1'b0;
    SW[7] = 1'b0;
    push(cyc + LAT, K_RELEASE, 1);
    push(cyc + LAT, K_RELEASE, 4);
    push(cyc + LAT, K_SW, 3);
    push(cyc + LAT, K_SW, 7);
    wait_n(10);

    // rst_req follows button 0; reset mid-count discards progress.
    button[0] = 1'b1;
    push(cyc + LAT, K_PRESS, 0);
    wait_n(8);
    button[3] = 1'b1;
    SW[5] = 1'b1;
    wait_n(3);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    push(cyc + LAT, K_PRESS, 0);
    push(cyc + LAT, K_PRESS, 3);
    push(cyc + LAT, K_SW, 5);
    wait_n(10);
    button[0] = 1'b0;
    button[3] = 1'b0;
    SW[5] = 1'b0;
    push(cyc + LAT, K_RELEASE, 0);
    push(cyc + LAT, K_RELEASE, 3);
    push(cyc + LAT, K_SW, 5);
    wait_n(10);

    chk("events_pending", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
